// File: rtl/ucode_mul_sequencer.sv
// ucode_mul_sequencer: expands a multiply-by-immediate macro request into a
// stream of MOV / CLR / ADDSHL micro-ops (shift-and-add over the immediate).
// Optional feature: define UCODE_MUL_EARLY_TERM_EN to skip clear immediate bits
// so that only set bits produce ADDSHL micro-ops; otherwise every bit position
// is visited and clear bits produce NOPs.
module ucode_mul_sequencer #(
  parameter int IMM_W       = 16,
  parameter int REG_AW      = 4,
  parameter int SCRATCH_REG = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clk_en,
  input  logic                       start_valid,
  output logic                       start_ready,
  input  logic [REG_AW-1:0]          start_rd,
  input  logic [REG_AW-1:0]          start_rs,
  input  logic [IMM_W-1:0]           start_imm,
  input  logic                       flush,
  output logic                       uop_valid,
  input  logic                       uop_ready,
  output logic [1:0]                 uop_kind,
  output logic [REG_AW-1:0]          uop_rd,
  output logic [REG_AW-1:0]          uop_rs,
  output logic [$clog2(IMM_W)-1:0]   uop_shamt,
  output logic                       uop_last,
  output logic                       busy,
  output logic                       err
);

  localparam int SHW = $clog2(IMM_W);

  localparam logic [1:0] KIND_NOP    = 2'd0;
  localparam logic [1:0] KIND_MOV    = 2'd1;
  localparam logic [1:0] KIND_CLR    = 2'd2;
  localparam logic [1:0] KIND_ADDSHL = 2'd3;

  localparam logic [REG_AW-1:0] SCRATCH = REG_AW'(SCRATCH_REG);

  typedef enum logic [1:0] {IDLE, COPY, CLEAR, ACCUM} stateT;

  stateT             state, stateNext;
  logic [SHW-1:0]    bitIdx, bitIdxNext;
  logic [REG_AW-1:0] rdLat, rsLat;
  logic [IMM_W-1:0]  immLat;
  logic              errReg;

  logic acceptReq, illegalReq, acceptLegal, handshake;

  // The scratch register holds the multiplicand copy, so naming it as either
  // operand would corrupt the result; such requests are swallowed with err.
  assign acceptReq   = start_valid & (state == IDLE) & clk_en & ~flush;
  assign illegalReq  = (start_rd == SCRATCH) | (start_rs == SCRATCH);
  assign acceptLegal = acceptReq & ~illegalReq;
  assign handshake   = (state != IDLE) & uop_ready & clk_en;

  assign start_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign err         = errReg;

`ifdef UCODE_MUL_EARLY_TERM_EN
  logic           anySet, hasNext;
  logic [SHW-1:0] firstIdx, nextIdx;

  // Lowest set bit overall (entry into ACCUM) and lowest set bit above the current index.
  always_comb begin
    anySet   = |immLat;
    firstIdx = '0;
    hasNext  = 1'b0;
    nextIdx  = '0;
    for (int j = IMM_W - 1; j >= 0; j--) begin
      if (immLat[j]) begin
        firstIdx = SHW'(j);
      end
      if (immLat[j] && (j > int'(bitIdx))) begin
        hasNext = 1'b1;
        nextIdx = SHW'(j);
      end
    end
  end
`endif

  // Next-state and micro-op decode; outputs are all-zero whenever no micro-op is presented.
  always_comb begin
    stateNext  = state;
    bitIdxNext = bitIdx;
    uop_valid  = 1'b0;
    uop_kind   = KIND_NOP;
    uop_rd     = '0;
    uop_rs     = '0;
    uop_shamt  = '0;
    uop_last   = 1'b0;

    case (state)
      IDLE: begin
        if (acceptLegal) begin
          stateNext  = COPY;
          bitIdxNext = '0;
        end
      end

      COPY: begin
        uop_valid = 1'b1;
        uop_kind  = KIND_MOV;
        uop_rd    = SCRATCH;
        uop_rs    = rsLat;
        if (handshake) begin
          stateNext = CLEAR;
        end
      end

      CLEAR: begin
        uop_valid = 1'b1;
        uop_kind  = KIND_CLR;
        uop_rd    = rdLat;
`ifdef UCODE_MUL_EARLY_TERM_EN
        uop_last  = ~anySet;
        if (handshake) begin
          stateNext  = anySet ? ACCUM : IDLE;
          bitIdxNext = anySet ? firstIdx : '0;
        end
`else
        if (handshake) begin
          stateNext  = ACCUM;
          bitIdxNext = '0;
        end
`endif
      end

      ACCUM: begin
        uop_valid = 1'b1;
`ifdef UCODE_MUL_EARLY_TERM_EN
        uop_kind  = KIND_ADDSHL;
        uop_rd    = rdLat;
        uop_rs    = SCRATCH;
        uop_shamt = bitIdx;
        uop_last  = ~hasNext;
        if (handshake) begin
          stateNext  = hasNext ? ACCUM : IDLE;
          bitIdxNext = hasNext ? nextIdx : '0;
        end
`else
        if (immLat[bitIdx]) begin
          uop_kind  = KIND_ADDSHL;
          uop_rd    = rdLat;
          uop_rs    = SCRATCH;
          uop_shamt = bitIdx;
        end
        uop_last = (bitIdx == SHW'(IMM_W - 1));
        if (handshake) begin
          if (uop_last) begin
            stateNext  = IDLE;
            bitIdxNext = '0;
          end else begin
            bitIdxNext = bitIdx + SHW'(1);
          end
        end
`endif
      end

      default: begin
        stateNext  = IDLE;
        bitIdxNext = '0;
      end
    endcase

    if (flush) begin
      stateNext  = IDLE;
      bitIdxNext = '0;
    end
  end

  // State, bit index, latched request fields and the err pulse; everything holds while clk_en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      bitIdx <= '0;
      rdLat  <= '0;
      rsLat  <= '0;
      immLat <= '0;
      errReg <= 1'b0;
    end else if (clk_en) begin
      state  <= stateNext;
      bitIdx <= bitIdxNext;
      errReg <= acceptReq & illegalReq;
      if (acceptLegal) begin
        rdLat  <= start_rd;
        rsLat  <= start_rs;
        immLat <= start_imm;
      end
    end
  end

endmodule

// File: tb/tb_ucode_mul_sequencer.sv
// tb_ucode_mul_sequencer: scoreboard bench for ucode_mul_sequencer. Expected
// micro-op streams are generated from the request when it is driven and
// matched against the DUT as micro-ops are handed off. Honors
// UCODE_MUL_EARLY_TERM_EN the same way the design does.
module tb_ucode_mul_sequencer;

  localparam int IMM_W = 16;
  localparam int REG_AW = 4;
  localparam int SCRATCH_REG = 15;
  localparam int SHW = $clog2(IMM_W);

  logic              clk = 1'b0;
  logic              rst;
  logic              clk_en;
  logic              start_valid;
  logic              start_ready;
  logic [REG_AW-1:0] start_rd;
  logic [REG_AW-1:0] start_rs;
  logic [IMM_W-1:0]  start_imm;
  logic              flush;
  logic              uop_valid;
  logic              uop_ready;
  logic [1:0]        uop_kind;
  logic [REG_AW-1:0] uop_rd;
  logic [REG_AW-1:0] uop_rs;
  logic [SHW-1:0]    uop_shamt;
  logic              uop_last;
  logic              busy;
  logic              err;

  typedef struct {
    logic [1:0]        kind;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [SHW-1:0]    shamt;
    logic              last;
  } uopT;

  uopT sb[$];
  int  vectors = 0;
  int  miscompares = 0;

  ucode_mul_sequencer #(
    .IMM_W(IMM_W), .REG_AW(REG_AW), .SCRATCH_REG(SCRATCH_REG)
  ) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_rd(start_rd), .start_rs(start_rs), .start_imm(start_imm),
    .flush(flush),
    .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_kind(uop_kind),
    .uop_rd(uop_rd), .uop_rs(uop_rs), .uop_shamt(uop_shamt),
    .uop_last(uop_last), .busy(busy), .err(err)
  );

  // Free-running core clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every vector and reports any miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Expected micro-op stream of one legal request.
  task automatic pushExpected(input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs, input logic [IMM_W-1:0] imm);
    uopT u;
    int  hi = -1;
    for (int i = 0; i < IMM_W; i++) if (imm[i]) hi = i;
    u = '{kind: 2'd1, rd: REG_AW'(SCRATCH_REG), rs: rs, shamt: '0, last: 1'b0};
    sb.push_back(u);
`ifdef UCODE_MUL_EARLY_TERM_EN
    u = '{kind: 2'd2, rd: rd, rs: '0, shamt: '0, last: (hi < 0)};
    sb.push_back(u);
    for (int i = 0; i < IMM_W; i++) begin
      if (imm[i]) begin
        u = '{kind: 2'd3, rd: rd, rs: REG_AW'(SCRATCH_REG), shamt: SHW'(i), last: (i == hi)};
        sb.push_back(u);
      end
    end
`else
    u = '{kind: 2'd2, rd: rd, rs: '0, shamt: '0, last: 1'b0};
    sb.push_back(u);
    for (int i = 0; i < IMM_W; i++) begin
      if (imm[i]) u = '{kind: 2'd3, rd: rd, rs: REG_AW'(SCRATCH_REG), shamt: SHW'(i), last: (i == IMM_W - 1)};
      else        u = '{kind: 2'd0, rd: '0, rs: '0, shamt: '0, last: (i == IMM_W - 1)};
      sb.push_back(u);
    end
`endif
  endtask

  // Handshake monitor: pops on accepted micro-ops, checks stalled outputs are frozen, idle outputs zero.
  always @(negedge clk) begin
    if (!rst && !flush && uop_valid) begin
      if (sb.size() == 0) begin
        if (uop_ready && clk_en) checkOutput("unexpectedUop", 32'd1, 32'd0);
      end else begin
        checkOutput("uopKind",  32'(uop_kind),  32'(sb[0].kind));
        checkOutput("uopRd",    32'(uop_rd),    32'(sb[0].rd));
        checkOutput("uopRs",    32'(uop_rs),    32'(sb[0].rs));
        checkOutput("uopShamt", 32'(uop_shamt), 32'(sb[0].shamt));
        checkOutput("uopLast",  32'(uop_last),  32'(sb[0].last));
        if (uop_ready && clk_en) void'(sb.pop_front());
      end
    end else if (!uop_valid) begin
      checkOutput("idleZero", {17'd0, uop_kind, uop_rd, uop_rs, uop_shamt, uop_last}, 32'd0);
    end
  end

  // Drive one request for a single accept edge; returns at posedge+1 after it.
  task automatic applyStimulus(input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs, input logic [IMM_W-1:0] imm);
    checkOutput("startReady", 32'(start_ready), 32'd1);
    if (rd != REG_AW'(SCRATCH_REG) && rs != REG_AW'(SCRATCH_REG)) pushExpected(rd, rs, imm);
    start_valid = 1'b1;
    start_rd = rd;
    start_rs = rs;
    start_imm = imm;
    @(posedge clk); #1;
    start_valid = 1'b0;
    start_rd = '0;
    start_rs = '0;
    start_imm = '0;
  endtask

  // Run until the scoreboard drains and the DUT is idle again; returns cycles spent.
  task automatic waitDone(input int budget, input bit randomReady, output int cycles);
    cycles = 0;
    while ((sb.size() != 0 || !start_ready) && cycles < budget) begin
      if (randomReady) uop_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cycles++;
    end
    uop_ready = 1'b1;
    if (cycles >= budget) checkOutput("doneTimeout", 32'd1, 32'd0);
  endtask

  // Advance until the DUT presents a given micro-op kind/shift amount.
  task automatic waitUop(input logic [1:0] kind, input int shamt, input int budget);
    int n = 0;
    while (!(uop_valid && uop_kind == kind && int'(uop_shamt) == shamt) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) checkOutput("waitUopTimeout", 32'd1, 32'd0);
  endtask

  int cycles;
  int expOps;
  logic [IMM_W-1:0] rImm;

  initial begin
    rst = 1'b1; clk_en = 1'b1; start_valid = 1'b0; start_rd = '0; start_rs = '0;
    start_imm = '0; flush = 1'b0; uop_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstStartReady", 32'(start_ready), 32'd1);
    checkOutput("rstValid", 32'(uop_valid), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstErr", 32'(err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] basic sequence rd=3 rs=2 imm=0x0005");
    applyStimulus(4'd3, 4'd2, 16'h0005);
    expOps = sb.size();
    checkOutput("validRise", 32'(uop_valid), 32'd1);
    checkOutput("busyAfterAccept", 32'(busy), 32'd1);
    checkOutput("readyLowBusy", 32'(start_ready), 32'd0);
    waitDone(100, 1'b0, cycles);
    checkOutput("seqCycles", 32'(cycles), 32'(expOps));
    checkOutput("busyAfterDone", 32'(busy), 32'd0);

    $display("[TB] boundary immediates");
    applyStimulus(4'd1, 4'd4, 16'h0000);
    waitDone(100, 1'b0, cycles);
    applyStimulus(4'd5, 4'd6, 16'h8000);
    waitDone(100, 1'b0, cycles);
    applyStimulus(4'd0, 4'd14, 16'hFFFF);
    waitDone(100, 1'b0, cycles);

    $display("[TB] stall during ACCUM at bit 2");
    applyStimulus(4'd7, 4'd8, 16'h00FF);
    waitUop(2'd3, 2, 50);
    uop_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checkOutput("stallShamt", 32'(uop_shamt), 32'd2);
      checkOutput("stallKind", 32'(uop_kind), 32'd3);
    end
    uop_ready = 1'b1;
    waitDone(100, 1'b0, cycles);

    $display("[TB] flush during ACCUM at bit 1");
    applyStimulus(4'd9, 4'd10, 16'h000F);
    waitUop(2'd3, 1, 50);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    sb.delete();
    checkOutput("flushValid", 32'(uop_valid), 32'd0);
    checkOutput("flushLast", 32'(uop_last), 32'd0);
    checkOutput("flushReady", 32'(start_ready), 32'd1);
    @(posedge clk); #1;
    applyStimulus(4'd9, 4'd10, 16'h000F);
    waitDone(100, 1'b0, cycles);

    $display("[TB] illegal requests");
    applyStimulus(4'd15, 4'd2, 16'h0003);
    checkOutput("errPulse", 32'(err), 32'd1);
    checkOutput("errNoValid", 32'(uop_valid), 32'd0);
    checkOutput("errIdle", 32'(start_ready), 32'd1);
    @(posedge clk); #1;
    checkOutput("errCleared", 32'(err), 32'd0);
    applyStimulus(4'd2, 4'd15, 16'h0003);
    checkOutput("errPulseRs", 32'(err), 32'd1);
    @(posedge clk); #1;
    checkOutput("errClearedRs", 32'(err), 32'd0);

    $display("[TB] clock enable hold in COPY");
    applyStimulus(4'd4, 4'd11, 16'h0021);
    clk_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checkOutput("holdKind", 32'(uop_kind), 32'd1);
      checkOutput("holdBusy", 32'(busy), 32'd1);
    end
    clk_en = 1'b1;
    waitDone(100, 1'b0, cycles);

    $display("[TB] reset during ACCUM");
    applyStimulus(4'd6, 4'd3, 16'h00FF);
    waitUop(2'd3, 3, 50);
    rst = 1'b1;
    clk_en = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    checkOutput("midRstReady", 32'(start_ready), 32'd1);
    checkOutput("midRstValid", 32'(uop_valid), 32'd0);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstFields", {20'd0, uop_kind, uop_rd, uop_shamt}, 32'd0);
    rst = 1'b0;
    clk_en = 1'b1;
    @(posedge clk); #1;

    $display("[TB] random requests with random backpressure");
    for (int t = 0; t < 6; t++) begin
      rImm = IMM_W'($urandom);
      applyStimulus(REG_AW'($urandom_range(0, 14)), REG_AW'($urandom_range(0, 14)), rImm);
      waitDone(400, 1'b1, cycles);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

endmodule
